// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and op classification helpers.
// Optional feature macro: MDU_MADD_EN (adds madd/maddu/msub/msubu).
package mdu_pkg;

    localparam int MDU_WIDTH_DEF       = 32;
    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // Ops that take the multiplier latency (accumulate forms only when enabled).
    function automatic logic is_mult(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Ops that take the divider latency.
    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Moves into HI/LO, which complete in the start cycle.
    function automatic logic is_mt(input logic [3:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the multiply/divide unit: maps (op, a, b, hi, lo)
// to the 64-bit {hi,lo} value that the op would leave behind.
// Optional feature macro: MDU_MADD_EN (accumulate/subtract forms).
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEF
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u, acc;
    logic               signed_div, a_neg, b_neg, div_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

    // Products are formed at double width so the low 2*WIDTH bits are exact
    // for both signed (sign-extended) and unsigned (zero-extended) operands.
    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx   = {{WIDTH{1'b0}}, a};
    assign b_zx   = {{WIDTH{1'b0}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign acc    = {hi, lo};

    // One unsigned divider serves both div and divu: signed division works on
    // magnitudes, then the quotient takes the XOR of the signs and the
    // remainder takes the sign of the dividend (truncation toward zero).
    assign signed_div = (op == OP_DIV);
    assign a_neg      = signed_div & a[WIDTH-1];
    assign b_neg      = signed_div & b[WIDTH-1];
    assign a_mag      = a_neg ? -a : a;
    assign b_mag      = b_neg ? -b : b;
    assign q_mag      = a_mag / b_mag;
    assign r_mag      = a_mag % b_mag;
    assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem        = a_neg ? -r_mag : r_mag;
    assign div_ovf    = signed_div && (a == INT_MIN) && (b == ALL_ONE);

    // Select the resulting {hi,lo}; unknown ops leave HI/LO as they are.
    always_comb begin
        result = acc;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b == '0)
                    result = {a, ALL_ONE};
                else if (div_ovf)
                    result = {{WIDTH{1'b0}}, INT_MIN};
                else
                    result = {rem, quot};
            end
            OP_MTHI:  result = {a, lo};
            OP_MTLO:  result = {hi, a};
`ifdef MDU_MADD_EN
            OP_MADD:  result = acc + prod_s;
            OP_MADDU: result = acc + prod_u;
            OP_MSUB:  result = acc - prod_s;
            OP_MSUBU: result = acc - prod_u;
`endif
            default:  result = acc;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed at the start edge into a pending register and
// committed to HI/LO after a fixed latency, modelling the real iterative unit.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu).
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = MDU_WIDTH_DEF,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] arith_res;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (arith_res)
    );

    // Next-state logic: launch from IDLE, count down in RUN, commit at count==1.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pending_d = pending_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mult(op)) begin
                        pending_d = arith_res;
                        count_d   = CNT_MULT;
                        state_d   = ST_RUN;
                    end else if (is_div(op)) begin
                        pending_d = arith_res;
                        count_d   = CNT_DIV;
                        state_d   = ST_RUN;
                    end else if (is_mt(op)) begin
                        {hi_d, lo_d} = arith_res;
                    end
                end
            end
            ST_RUN: begin
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    {hi_d, lo_d} = pending_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; an asynchronous reset drops any in-flight result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            pending_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = start | (count_q != '0);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // The stall unit must hold back new muldiv ops while the unit is running.
    a_no_start_in_run : assert property (
        @(posedge clk) disable iff (!reset_n) !(start && (count_q != '0))
    ) else $warning("muldiv_unit: start while running is ignored");

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table-driven vectors through a
// scoreboard plus hand-written sequences for the multi-cycle corner cases.
// Optional feature macro: MDU_MADD_EN (adds an accumulate vector).
module tb_muldiv_unit;
    import mdu_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic [3:0]  op      = OP_NONE;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;
    logic        busy;
    logic [31:0] hi, lo;

    muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cycles;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [3:0] vop, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                          input int ec);
        vec_t v;
        v.name = name; v.op = vop; v.a = va; v.b = vb;
        v.exp_hi = eh; v.exp_lo = el; v.exp_cycles = ec;
        vecs.push_back(v);
    endtask

    task automatic pushExp(input string name, input logic [31:0] eh, input logic [31:0] el,
                           input int ec);
        exp_t e;
        e.name = name; e.exp_hi = eh; e.exp_lo = el; e.exp_cycles = ec;
        sb.push_back(e);
    endtask

    // Wait (bounded) for busy to drop, counting the cycles it stays high.
    task automatic waitIdle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s timeout: busy still 1, expected 0 within 40 cycles", name);
        end
    endtask

    // Issue one op for a single cycle, record its expectation, run to idle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        pushExp(v.name, v.exp_hi, v.exp_lo, v.exp_cycles);
        #1 checkValue({v.name, " busy in start cycle"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1 start = 1'b0; op = OP_NONE;
        busy_cycles = 1;
        waitIdle(v.name);
    endtask

    // Pop the oldest expectation and compare HI/LO and the busy length.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            checkValue({e.name, " hi"}, hi, e.exp_hi);
            checkValue({e.name, " lo"}, lo, e.exp_lo);
            checkValue({e.name, " busy cycles"}, 32'(busy_cycles), 32'(e.exp_cycles));
        end
    endtask

    // Main test sequence.
    initial begin
        logic late_activity;

        addVec("mult -2*3",        OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 6);
        addVec("multu max*max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 6);
        addVec("div -7/2",         OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 11);
        addVec("divu 5/0",         OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 11);
        addVec("div min/-1",       OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 11);
        addVec("divu 100/7",       OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        11);
        addVec("div 7/-2",         OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 11);
        addVec("div -7/0",         OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 11);
        addVec("multu 2^16*2^16",  OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         6);
        addVec("mult min*min",     OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         6);
        addVec("mthi",             OP_MTHI,  32'h0000_1234, 32'd9,         32'h0000_1234, 32'd0,         1);
        addVec("mtlo",             OP_MTLO,  32'h0000_5678, 32'd9,         32'h0000_1234, 32'h0000_5678, 1);
        addVec("none",             OP_NONE,  32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0000_1234, 32'h0000_5678, 1);
        addVec("undefined op 15",  4'd15,    32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0000_1234, 32'h0000_5678, 1);
`ifdef MDU_MADD_EN
        addVec("mthi 0",           OP_MTHI,  32'd0,         32'd0,         32'd0,         32'h0000_5678, 1);
        addVec("mtlo ones",        OP_MTLO,  32'hFFFF_FFFF, 32'd0,         32'd0,         32'hFFFF_FFFF, 1);
        addVec("madd 1*1",         OP_MADD,  32'd1,         32'd1,         32'd1,         32'd0,         6);
`else
        addVec("madd code unused", OP_MADD,  32'd1,         32'd1,         32'h0000_1234, 32'h0000_5678, 1);
`endif

        // Reset state.
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkValue("reset busy", 32'(busy), 32'd0);
        checkValue("reset hi", hi, 32'd0);
        checkValue("reset lo", lo, 32'd0);
        reset_n = 1'b1;

        // mthi then mtlo on back-to-back cycles.
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'h0000_1234;
        #1 checkValue("mthi busy", 32'(busy), 32'd1);
        @(negedge clk);
        op = OP_MTLO; a = 32'h0000_5678;
        #1 checkValue("mthi hi after edge", hi, 32'h0000_1234);
        checkValue("mtlo busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        #1 checkValue("mt pair busy low", 32'(busy), 32'd0);
        checkValue("mt pair hi", hi, 32'h0000_1234);
        checkValue("mt pair lo", lo, 32'h0000_5678);

        // A second start while running must be ignored.
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
        pushExp("multu with ignored start", 32'd0, 32'd12, 6);
        @(posedge clk);
        #1 start = 1'b0; op = OP_NONE;
        busy_cycles = 1;
        @(negedge clk);
        if (busy) busy_cycles++;
        start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 start = 1'b0; op = OP_NONE;
        checkValue("ignored mthi hi", hi, 32'h0000_1234);
        checkValue("ignored mthi lo", lo, 32'h0000_5678);
        waitIdle("multu with ignored start");
        checkOutput();

        // Table-driven vectors.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Asynchronous reset in the 4th run cycle of a divide.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; op = OP_NONE;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1 checkValue("async reset busy", 32'(busy), 32'd0);
        checkValue("async reset hi", hi, 32'd0);
        checkValue("async reset lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        late_activity = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (busy || hi != 32'd0 || lo != 32'd0) late_activity = 1'b1;
        end
        checkValue("no late commit", 32'(late_activity), 32'd0);
        checkValue("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
